decoder_5to32_tree: RTL and testbench

- Registered 5-to-32 one-hot decoder with an active-high enable.
- Built as a tree: one 2-to-4 stage on the upper address bits drives four 3-to-8 stages on the lower bits.
- Also exports the four group-select lines from the 2-to-4 stage.
- Used as the register-file and address select decoder in the single-cycle datapath.

---
 rtl/decoder_5to32_tree_if.sv | 11 +
 rtl/decoder_5to32_tree.sv | 80 ++++++++
 tb/tb_decoder_5to32_tree.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/decoder_5to32_tree_if.sv
// Decoder bus: binary select and enable in, registered one-hot decode and
// group selects out. All vectors use ascending ranges (index 0 = MSB).
interface decoder_5to32_tree_if;
  logic [0:4]  x;
  logic        en;
  logic [0:31] z;
  logic [0:3]  enable;

  modport master (output x, output en, input z, input enable);
  modport slave  (input x, input en, output z, output enable);
endinterface

// File: rtl/decoder_5to32_tree.sv
// Registered 5-to-32 one-hot decoder built as a tree: a 2-to-4 stage on
// x[0:1] gates four 3-to-8 stages on x[2:4]. Bit index equals decoded value.

// 2-to-4 stage: y[g] = en AND (x == g)
module dec_tree_2to4 (
  input  logic [0:1] x,
  input  logic       en,
  output logic [0:3] y
);
  // One-hot decode of the upper two select bits
  always_comb begin
    y = '0;
    for (int unsigned g = 0; g < 4; g++) begin
      y[g] = en && (x == 2'(g));
    end
  end
endmodule

// 3-to-8 stage: y[k] = en AND (x == k)
module dec_tree_3to8 (
  input  logic [0:2] x,
  input  logic       en,
  output logic [0:7] y
);
  // One-hot decode of the lower three select bits
  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      y[k] = en && (x == 3'(k));
    end
  end
endmodule

module decoder_5to32_tree (
  input  logic                 clk,
  input  logic                 rst,
  decoder_5to32_tree_if.slave  bus
);
  logic [0:3]  grp_sel;
  logic [0:7]  leaf_y [0:3];
  logic [0:31] z_d, z_q;
  logic [0:3]  enable_d, enable_q;

  dec_tree_2to4 u_grp (
    .x  (bus.x[0:1]),
    .en (bus.en),
    .y  (grp_sel)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    dec_tree_3to8 u_leaf (
      .x  (bus.x[2:4]),
      .en (grp_sel[g]),
      .y  (leaf_y[g])
    );
  end

  // Concatenate the four leaf decodes; leaf g covers outputs 8g..8g+7
  always_comb begin
    z_d      = '0;
    enable_d = grp_sel;
    for (int unsigned g = 0; g < 4; g++) begin
      z_d[8*g +: 8] = leaf_y[g];
    end
  end

  // Output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q      <= '0;
      enable_q <= '0;
    end else begin
      z_q      <= z_d;
      enable_q <= enable_d;
    end
  end

  assign bus.z      = z_q;
  assign bus.enable = enable_q;
endmodule

// File: tb/tb_decoder_5to32_tree.sv
// Bench for decoder_5to32_tree: directed vector table, exhaustive sweep with
// a mid-sweep reset, and random stimulus against a behavioural model.
module tb_decoder_5to32_tree;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decoder_5to32_tree_if bus ();

  decoder_5to32_tree dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r;
    logic        e;
    logic [4:0]  xv;
    logic [31:0] exp_z;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [0:11];

  // Model: z[i] set for i == x (index 0 is leftmost), group = x / 8
  function automatic logic [31:0] model_z(input logic r, input logic e, input logic [4:0] xv);
    if (r || !e) return 32'h0;
    return 32'h8000_0000 >> xv;
  endfunction

  function automatic logic [3:0] model_en(input logic r, input logic e, input logic [4:0] xv);
    if (r || !e) return 4'h0;
    return 4'b1000 >> (int'(xv) / 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later
  task automatic cycle(input logic r, input logic e, input logic [4:0] xv);
    @(negedge clk);
    rst    = r;
    bus.en = e;
    bus.x  = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic r, input logic e, input logic [4:0] xv);
    logic [31:0] zv;
    logic [3:0]  ev;
    zv = bus.z;
    ev = bus.enable;
    chk({name, ".z"}, zv, model_z(r, e, xv));
    chk({name, ".enable"}, {28'h0, ev}, {28'h0, model_en(r, e, xv)});
  endtask

  task automatic check_invariants(input string name);
    logic [0:31] zv;
    logic [0:3]  ev;
    logic        ok;
    zv = bus.z;
    ev = bus.enable;
    ok = ($countones(zv) == $countones(ev)) && ($countones(zv) <= 1);
    for (int i = 0; i < 32; i++) begin
      if (zv[i] === 1'b1 && ev[i/8] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s.invariant: z=%h enable=%b", name, zv, ev);
    end
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.x  = '0;

    vecs[0]  = '{"reset",      1'b1, 1'b1, 5'b10101, 32'h0000_0000, 4'b0000};
    vecs[1]  = '{"x0",         1'b0, 1'b1, 5'b00000, 32'h8000_0000, 4'b1000};
    vecs[2]  = '{"x1",         1'b0, 1'b1, 5'b00001, 32'h4000_0000, 4'b1000};
    vecs[3]  = '{"x2",         1'b0, 1'b1, 5'b00010, 32'h2000_0000, 4'b1000};
    vecs[4]  = '{"x7",         1'b0, 1'b1, 5'b00111, 32'h0100_0000, 4'b1000};
    vecs[5]  = '{"x8",         1'b0, 1'b1, 5'b01000, 32'h0080_0000, 4'b0100};
    vecs[6]  = '{"x16",        1'b0, 1'b1, 5'b10000, 32'h0000_8000, 4'b0010};
    vecs[7]  = '{"x31",        1'b0, 1'b1, 5'b11111, 32'h0000_0001, 4'b0001};
    vecs[8]  = '{"x11_en0",    1'b0, 1'b0, 5'b01011, 32'h0000_0000, 4'b0000};
    vecs[9]  = '{"x11_en1",    1'b0, 1'b1, 5'b01011, 32'h0010_0000, 4'b0100};
    vecs[10] = '{"rst_mid",    1'b1, 1'b1, 5'b00100, 32'h0000_0000, 4'b0000};
    vecs[11] = '{"post_rst",   1'b0, 1'b1, 5'b00100, 32'h0800_0000, 4'b1000};

    // Directed table
    for (int i = 0; i < 12; i++) begin
      logic [31:0] zv;
      logic [3:0]  ev;
      cycle(vecs[i].r, vecs[i].e, vecs[i].xv);
      zv = bus.z;
      ev = bus.enable;
      chk({vecs[i].name, ".z"}, zv, vecs[i].exp_z);
      chk({vecs[i].name, ".enable"}, {28'h0, ev}, {28'h0, vecs[i].exp_en});
    end

    // Sweep every x twice, second pass with en toggling, reset pulsed mid-sweep
    for (int i = 0; i < 64; i++) begin
      logic [4:0] xv;
      logic       e;
      logic       r;
      xv = 5'(i % 32);
      e  = (i < 32) ? 1'b1 : 1'(i % 2);
      r  = (i == 40);
      cycle(r, e, xv);
      check_outputs($sformatf("sweep%0d", i), r, e, xv);
      check_invariants($sformatf("sweep%0d", i));
    end

    // Random stimulus with occasional reset
    for (int i = 0; i < 300; i++) begin
      logic [4:0] xv;
      logic       e;
      logic       r;
      xv = 5'($urandom_range(0, 31));
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 19) == 0);
      cycle(r, e, xv);
      check_outputs($sformatf("rand%0d", i), r, e, xv);
      check_invariants($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
